// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, op classification helpers and writeback state encoding
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0101;
  localparam logic [OP_W-1:0] OP_MOVE = 4'b0111;
  localparam logic [OP_W-1:0] OP_SWAP = 4'b1000;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2
  } wb_state_e;

  // Ops that produce two register writes (quotient/remainder, swapped pair).
  function automatic logic is_pair_op(input logic [OP_W-1:0] op);
    case (op)
      OP_DIV, OP_SWAP: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic ovf_relevant(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_MOVE, OP_SWAP, OP_AND, OP_OR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_seq.sv
// rtl/alu_writeback_seq.sv - serializes ALU result bundles onto the register file write port
module alu_writeback_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic [DATA_W-1:0] i_upper,
  input  logic [DATA_W-1:0] i_lower,
  input  logic              i_overflow,
  input  logic [ADDR_W-1:0] i_dest_a,
  input  logic [ADDR_W-1:0] i_dest_b,
  input  logic              i_ovf_clear,
  output logic              o_reg_write,
  output logic [ADDR_W-1:0] o_write_addr,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_ovf_flag,
  output logic              o_illegal_op
);

  wb_state_e         r_state;
  logic              r_pair;
  logic [DATA_W-1:0] r_hold_upper;
  logic [ADDR_W-1:0] r_hold_dest_b;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic              r_ovf_flag;
  logic              r_illegal_op;

  logic w_ready;
  logic w_xfer;
  logic w_legal;
  logic w_pair;
  logic w_ovf_hit;

  // The only stall is the cycle the first half of a pair is being written.
  assign w_ready   = !((r_state == ST_WR1) && r_pair);
  assign w_xfer    = i_valid && w_ready;
  assign w_legal   = is_legal_op(i_alu_op);
  assign w_pair    = w_legal && is_pair_op(i_alu_op);
  assign w_ovf_hit = w_xfer && ovf_relevant(i_alu_op) && i_overflow;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pair        <= 1'b0;
      r_hold_upper  <= '0;
      r_hold_dest_b <= '0;
      r_reg_write   <= 1'b0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
      r_ovf_flag    <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else begin
      r_reg_write  <= 1'b0;
      r_illegal_op <= 1'b0;

      // A new overflow takes priority over a simultaneous clear.
      if (w_ovf_hit) begin
        r_ovf_flag <= 1'b1;
      end else if (i_ovf_clear) begin
        r_ovf_flag <= 1'b0;
      end

      if ((r_state == ST_WR1) && r_pair) begin
        r_state      <= ST_WR2;
        r_pair       <= 1'b0;
        r_reg_write  <= 1'b1;
        r_write_addr <= r_hold_dest_b;
        r_write_data <= r_hold_upper;
      end else if (w_xfer) begin
        r_state       <= ST_WR1;
        r_pair        <= w_pair;
        r_hold_upper  <= i_upper;
        r_hold_dest_b <= i_dest_b;
        if (!w_legal) begin
          r_illegal_op <= 1'b1;
        end else if (!w_ovf_hit) begin
          r_reg_write  <= 1'b1;
          r_write_addr <= i_dest_a;
          r_write_data <= i_lower;
        end
      end else begin
        r_state <= ST_IDLE;
        r_pair  <= 1'b0;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_reg_write  = r_reg_write;
  assign o_write_addr = r_write_addr;
  assign o_write_data = r_write_data;
  assign o_ovf_flag   = r_ovf_flag;
  assign o_illegal_op = r_illegal_op;

endmodule

// File: tb/tb_alu_writeback_seq.sv
// tb/tb_alu_writeback_seq.sv - randomized and directed checks against a write-list reference model
module tb_alu_writeback_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [3:0]  alu_op;
  logic [15:0] upper;
  logic [15:0] lower;
  logic        overflow;
  logic [3:0]  dest_a;
  logic [3:0]  dest_b;
  logic        ovf_clear;
  logic        reg_write;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        ovf_flag;
  logic        illegal_op;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference state: what the next edge should produce, plus any owed second write.
  logic        m_we, m_ill, m_ovf, m_ready, m_pend;
  logic [3:0]  m_addr, m_pend_addr;
  logic [15:0] m_data, m_pend_data;

  always #5 clk = ~clk;

  alu_writeback_seq #(.DATA_W(16), .ADDR_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_alu_op(alu_op), .i_upper(upper), .i_lower(lower), .i_overflow(overflow),
    .i_dest_a(dest_a), .i_dest_b(dest_b), .i_ovf_clear(ovf_clear),
    .o_reg_write(reg_write), .o_write_addr(write_addr), .o_write_data(write_data),
    .o_ovf_flag(ovf_flag), .o_illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11};
  endfunction

  task automatic model_edge();
    bit ovf_set = 0;
    m_we  = 0;
    m_ill = 0;
    if (rst) begin
      m_addr = 0; m_data = 0; m_ovf = 0; m_pend = 0;
    end else begin
      if (m_pend) begin
        m_we = 1; m_addr = m_pend_addr; m_data = m_pend_data; m_pend = 0;
      end else if (valid) begin
        if (!op_legal(alu_op)) m_ill = 1;
        else if ((alu_op == 4'd0 || alu_op == 4'd1 || alu_op == 4'd4) && overflow) ovf_set = 1;
        else begin
          m_we = 1; m_addr = dest_a; m_data = lower;
          if (alu_op == 4'd5 || alu_op == 4'd8) begin
            m_pend = 1; m_pend_addr = dest_b; m_pend_data = upper;
          end
        end
      end
      if (ovf_set) m_ovf = 1;
      else if (ovf_clear) m_ovf = 0;
    end
    m_ready = !m_pend;
  endtask

  task automatic check_outputs();
    chk("reg_write", reg_write, m_we);
    chk("write_addr", write_addr, m_addr);
    chk("write_data", write_data, m_data);
    chk("ovf_flag", ovf_flag, m_ovf);
    chk("illegal_op", illegal_op, m_ill);
  endtask

  task automatic step();
    chk("ready", ready, m_ready);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] up,
                       input logic [15:0] lo, input logic ov, input logic [3:0] da,
                       input logic [3:0] db, input logic clr, input logic r);
    valid = v; alu_op = op; upper = up; lower = lo; overflow = ov;
    dest_a = da; dest_b = db; ovf_clear = clr; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 0);
      step();
    end
  endtask

  initial begin
    drive(0, 4'd0, 16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 1);
    @(posedge clk); #1;
    model_edge();
    check_outputs();
    rst = 0;
    chk("ready_after_rst", ready, 1'b1);

    // Add -> write 0x1234 to r3
    drive(1, 4'd0, 16'h0, 16'h1234, 0, 4'd3, 4'd0, 0, 0); step();
    chk("add_data", write_data, 16'h1234);
    idle(1);

    // Div -> 0x0007 to r4, then 0x0002 to r5, one-cycle stall
    drive(1, 4'd5, 16'h0002, 16'h0007, 0, 4'd4, 4'd5, 0, 0); step();
    chk("div_stall", ready, 1'b0);
    idle(2);

    // Overflow stickiness and set-over-clear priority
    drive(1, 4'd0, 16'h0, 16'h1111, 1, 4'd1, 4'd0, 0, 0); step();
    drive(1, 4'd0, 16'h0, 16'h2222, 0, 4'd1, 4'd0, 0, 0); step();
    drive(0, 4'd0, 16'h0, 16'h0, 0, 4'd0, 4'd0, 1, 0); step();
    drive(1, 4'd4, 16'h0, 16'h3333, 1, 4'd2, 4'd0, 1, 0); step();
    chk("ovf_set_wins", ovf_flag, 1'b1);
    // Overflow ignored for Move
    drive(1, 4'd7, 16'h0, 16'h4444, 1, 4'd2, 4'd0, 1, 0); step();
    idle(1);

    // Or, Swap with DestA == DestB, Move held through the stall
    drive(1, 4'd11, 16'h0, 16'h00F0, 0, 4'd1, 4'd0, 0, 0); step();
    drive(1, 4'd8, 16'h5555, 16'hAAAA, 0, 4'd6, 4'd6, 0, 0); step();
    drive(1, 4'd7, 16'h0, 16'hBEEF, 0, 4'd7, 4'd0, 0, 0); step();
    step();
    chk("move_after_stall", write_data, 16'hBEEF);
    idle(2);

    // Illegal op pulses once, no write
    drive(1, 4'd3, 16'h0, 16'h9999, 0, 4'd9, 4'd0, 0, 0); step();
    idle(2);

    // Reset during the first write of a Swap drops the second write
    drive(1, 4'd8, 16'h5678, 16'h1234, 0, 4'd2, 4'd3, 0, 0); step();
    drive(0, 4'd0, 16'h0, 16'h0, 0, 4'd0, 4'd0, 0, 1); step();
    rst = 0;
    chk("ready_post_rst", ready, 1'b1);
    idle(2);

    // Randomized traffic across all op codes
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
            16'($urandom), $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback_seq.md
# alu_writeback_seq

Result writeback sequencer at the consuming end of the ALU result interface. Accepts one ALU result bundle (Upper, Lower, Overflow plus the op and destination tags), and serializes it onto the register file's single write port. Single-result ops take one write cycle; Div and Swap take two. It also maintains a sticky overflow status bit. It sits between the ALU and the register file in the datapath.

## Interface
- DATA_W, 16, width of Upper/Lower/WriteData
- ADDR_W, 4, register address width
- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- Valid  in  1  result bundle present this cycle
- Ready  out  1  sequencer accepts bundle this cycle (transfer = Valid & Ready)
- ALUOp  in  4  op that produced the result
- Upper  in  DATA_W  ALU upper result
- Lower  in  DATA_W  ALU lower result
- Overflow  in  1  ALU overflow indication
- DestA  in  ADDR_W  primary destination register
- DestB  in  ADDR_W  secondary destination register (Div, Swap only)
- OvfClear  in  1  clears OvfFlag
- RegWrite  out  1  register-file write enable
- WriteAddr  out  ADDR_W  write address
- WriteData  out  DATA_W  write data
- OvfFlag  out  1  sticky overflow status
- IllegalOp  out  1  one-cycle pulse on accepted undefined op

## Operation
- Op classes (shared constants): Add 0000, Sub 0001, Mul 0100, Div 0101, Move 0111, Swap 1000, And 1001, Or 1011; every other code is illegal.
- Single-write ops: Add, Sub, Mul, Move, And, Or. These write Lower to DestA.
- Pair ops: Div writes Lower (quotient) to DestA, then Upper (remainder) to DestB. Swap writes Lower to DestA, then Upper to DestB.
- Overflow is honoured only for Add, Sub and Mul. If it is 1: no write, and OvfFlag is set. It is ignored for every other op.
- Illegal op: no write. IllegalOp pulses in the cycle a write would have occurred.
- FSM states: IDLE, WR1, WR2.
  - Transfer of a single-write op goes to WR1 with Pair=0.
  - Transfer of a pair op goes to WR1 with Pair=1.
  - WR1 with Pair=1 goes to WR2.
  - WR1 with Pair=0 goes to WR1 on a new transfer, otherwise to IDLE.
  - WR2 goes to WR1 on a new transfer, otherwise to IDLE.
- Ready = 0 only in WR1 with Pair=1. It is 1 in all other states, including during reset release.
- The accepted bundle is captured in holding registers. Inputs are not used after the transfer cycle.
- OvfFlag: set wins over OvfClear when both occur in the same cycle. Cleared only by OvfClear or Rst.

## Timing
- Reset values: state IDLE, RegWrite 0, WriteAddr 0, WriteData 0, OvfFlag 0, IllegalOp 0. Ready is 1 in the cycle after Rst deasserts.
- Latency: a transfer at edge N gives the first write with RegWrite=1 in cycle N+1 (registered outputs). A pair op's second write is in cycle N+2.
- Throughput: one single-write op per cycle back-to-back. A pair op blocks for exactly one cycle.
- While RegWrite=0, WriteAddr and WriteData hold their last values.
- DestA == DestB on a pair op: both writes are issued, so the Upper value remains.
- Rst asserted mid-pair (in WR1, Pair=1): the second write is dropped and the FSM returns to IDLE on that edge.
- Valid is held while Ready=0: no transfer occurs and the bundle is not double-counted.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit op constants;
  - an is_pair_op function (Div, Swap);
  - an ovf_relevant function (Add, Sub, Mul);
  - the state encoding.
- The ALU imports the same op constants.
- Single module. No sub-module is needed. Roughly 150–200 lines of RTL.

## Test plan
- Rst, then Add with Lower=0x1234, DestA=3, Overflow=0 -> next cycle RegWrite=1, WriteAddr=3, WriteData=0x1234. Ready stays 1 throughout.
- Div with Lower=0x0007, Upper=0x0002, DestA=4, DestB=5 -> cycle N+1 writes 0x0007 to 4, cycle N+2 writes 0x0002 to 5. Ready=0 during N+1.
- Add with Overflow=1 -> no RegWrite and OvfFlag=1. An Add with Overflow=0 next leaves OvfFlag=1. OvfClear then gives 0. OvfClear in the same cycle as a new overflow leaves OvfFlag=1.
- Back-to-back Or, Swap (Lower=0xAAAA, Upper=0x5555, DestA=DestB=6), Move with Valid held high -> writes are Or, 0xAAAA to 6, 0x5555 to 6, then Move. Move is accepted only after the Ready stall.
- ALUOp=0011 -> no write and IllegalOp pulses once.
- Rst during WR1 of a Swap -> second write is absent. Outputs return to reset values and Ready=1.
